// File: rtl/pipelined_cla_addsub.sv
// Two-stage pipelined carry-look-ahead adder/subtractor with valid/ready handshake.
// Optional build macro CLA_SATURATE_EN clamps overflowing results to the signed range.
module pipelined_cla_addsub #(
  parameter int BUS_WIDTH       = 32,
  parameter int CLA_BLOCK_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 add_sub_b,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero
);

  localparam int NBLK = BUS_WIDTH / CLA_BLOCK_WIDTH;
  localparam int MSB  = BUS_WIDTH - 1;

  if (BUS_WIDTH % CLA_BLOCK_WIDTH != 0) begin : g_width_check
    $error("BUS_WIDTH must be an integer multiple of CLA_BLOCK_WIDTH");
  end

  // Handshake and stage-1 state
  logic            adv1, adv2;
  logic            s1_valid_q, s1_valid_d;
  logic [MSB:0]    a_q, a_d, b_q, b_d;
  logic            cin_q, cin_d;
  logic [NBLK-1:0] blk_g_q, blk_g_d, blk_p_q, blk_p_d;
  logic [MSB:0]    b_eff, g1, p1;
  logic            bg, bp;

  // Stage-2 state
  logic            out_valid_q, out_valid_d;
  logic [MSB:0]    out_q, out_d;
  logic            cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [NBLK:0]   blk_c;
  logic [MSB:0]    sum_c, res_c;
  logic            c_bit, c_msb, ovf_c, term;

  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  // NOTE: every variable in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin : s1_comb
    b_eff      = in2 ^ {BUS_WIDTH{add_sub_b}};
    g1         = in1 & b_eff;
    p1         = in1 ^ b_eff;
    bg         = 1'b0;
    bp         = 1'b1;
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    blk_g_d    = blk_g_q;
    blk_p_d    = blk_p_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d   = in1;
        b_d   = b_eff;
        cin_d = add_sub_b;
        for (int k = 0; k < NBLK; k++) begin
          bg = 1'b0;
          bp = 1'b1;
          for (int i = 0; i < CLA_BLOCK_WIDTH; i++) begin
            bg = g1[k*CLA_BLOCK_WIDTH+i] | (p1[k*CLA_BLOCK_WIDTH+i] & bg);
            bp = bp & p1[k*CLA_BLOCK_WIDTH+i];
          end
          blk_g_d[k] = bg;
          blk_p_d[k] = bp;
        end
      end
    end
  end

  always_comb begin : s2_comb
    blk_c = '0;
    sum_c = '0;
    c_bit = 1'b0;
    c_msb = 1'b0;
    term  = 1'b0;
    // Each block carry-in is a flat sum of products of block G/P and cin.
    for (int k = 0; k <= NBLK; k++) begin
      term = cin_q;
      for (int m = 0; m < k; m++) term = term & blk_p_q[m];
      blk_c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = blk_g_q[j];
        for (int m = j + 1; m < k; m++) term = term & blk_p_q[m];
        blk_c[k] = blk_c[k] | term;
      end
    end
    for (int k = 0; k < NBLK; k++) begin
      c_bit = blk_c[k];
      for (int i = 0; i < CLA_BLOCK_WIDTH; i++) begin
        sum_c[k*CLA_BLOCK_WIDTH+i] = a_q[k*CLA_BLOCK_WIDTH+i] ^ b_q[k*CLA_BLOCK_WIDTH+i] ^ c_bit;
        if (k*CLA_BLOCK_WIDTH + i == MSB) c_msb = c_bit;
        c_bit = (a_q[k*CLA_BLOCK_WIDTH+i] & b_q[k*CLA_BLOCK_WIDTH+i]) |
                ((a_q[k*CLA_BLOCK_WIDTH+i] ^ b_q[k*CLA_BLOCK_WIDTH+i]) & c_bit);
      end
    end
    ovf_c = c_msb ^ blk_c[NBLK];
`ifdef CLA_SATURATE_EN
    // On overflow both operands share the sign of a_q, which picks the clamp direction.
    res_c = !ovf_c ? sum_c :
            a_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
`else
    res_c = sum_c;
`endif
    out_valid_d = out_valid_q;
    out_d       = out_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d  = res_c;
        cout_d = blk_c[NBLK];
        ovf_d  = ovf_c;
        zero_d = (res_c == '0);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  // NOTE: stage-1 data flops have no reset; s1_valid_q qualifies them, so stale contents are never used.
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    cin_q   <= cin_d;
    blk_g_q <= blk_g_d;
    blk_p_q <= blk_p_d;
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter CLA_BLOCK_WIDTH, default 4: look-ahead block width; BUS_WIDTH SHALL be an integer multiple of it.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand beat present.
REQ-006 SHALL have port in_ready, output, 1: block accepts operand beat this cycle.
REQ-007 SHALL have port add_sub_b, input, BUS_WIDTH-independent 1 bit: 0 = add, 1 = subtract (in1 - in2).
REQ-008 SHALL have ports in1 and in2, input, BUS_WIDTH each: operands, two's complement.
REQ-009 SHALL have port out_valid, output, 1: result beat present.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-011 SHALL have port out, output, BUS_WIDTH: result.
REQ-012 SHALL have ports cout, ovf, zero, output, 1 each: carry-out (subtract: 1 = no borrow), signed overflow, result == 0.

Function
REQ-013 SHALL subtract by inverting in2 and forcing carry-in to 1; add uses carry-in 0.
REQ-014 SHALL compute carries with per-block generate/propagate and block-level look-ahead of BUS_WIDTH/CLA_BLOCK_WIDTH groups, no ripple across blocks.
REQ-015 SHALL be a two-stage pipeline: stage 1 registers operands, op and per-block G/P; stage 2 registers out, cout, ovf, zero.
REQ-016 SHALL have latency exactly 2 cycles from accepting beat (in_valid && in_ready) to out_valid with no backpressure.
REQ-017 SHALL sustain one beat per cycle while out_ready is held 1.
REQ-018 SHALL advance stage 2 when !out_valid || out_ready; stage 1 when stage 1 empty or stage 2 advances; in_ready equals stage-1 advance condition.
REQ-019 SHALL hold out, flags and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL compute ovf = carry into MSB XOR carry out of MSB.
REQ-021 SHALL drop no beat and duplicate no beat under any in_valid/out_ready pattern, including simultaneous accept and emit.
REQ-022 SHALL let in_ready depend combinationally on out_ready only; no path from in_valid to in_ready.

Reset
REQ-023 SHALL on rst clear both stage valid bits; out_valid = 0, out = 0, cout = 0, ovf = 0, zero = 0 next cycle.
REQ-024 SHALL discard in-flight beats when rst asserts mid-operation; in_ready = 1 in the first cycle after rst deasserts.
REQ-025 SHALL ignore in_valid while rst = 1.

Configuration
REQ-026 SHALL with macro CLA_SATURATE_EN defined clamp on ovf: positive overflow -> 2^(BUS_WIDTH-1)-1, negative -> -2^(BUS_WIDTH-1); ovf still reports 1; zero computed on clamped value.
REQ-027 SHALL without CLA_SATURATE_EN output the wrapped modulo-2^BUS_WIDTH result; latency unchanged in both builds.

Verification
REQ-028 Add 0x00000005 + 0x00000003 -> out 0x00000008, cout 0, ovf 0, zero 0, out_valid exactly 2 cycles after accept.
REQ-029 Sub 0x00000003 - 0x00000005 -> out 0xFFFFFFFE, cout 0, ovf 0; sub 5 - 5 -> out 0, cout 1, zero 1.
REQ-030 Add 0x7FFFFFFF + 0x00000001 -> ovf 1; out 0x80000000 without CLA_SATURATE_EN, 0x7FFFFFFF with it; sub 0x80000000 - 1 -> ovf 1, saturated 0x80000000.
REQ-031 Stream 8 back-to-back beats, out_ready low 3 cycles mid-stream -> in_ready low after pipeline fills, all 8 results in order, none lost, outputs stable while stalled.
REQ-032 Accept 2 beats, assert rst 1 cycle -> out_valid 0 next cycle, no stale result emitted; new beat after reset returns correct result in 2 cycles.
